// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: sample-buffered PWM DAC.
// A small FIFO takes unsigned duty codes through a valid/ready handshake. Each
// PWM period is 2^CODE_WIDTH clocks long and outputs one code. When a period
// ends with the FIFO empty, the previous code is repeated and a saturating
// underrun counter increments.
module audio_pwm_dac #(
  parameter int unsigned CODE_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CODE_WIDTH-1:0]         sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] duty;
  logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;
  logic                  boundary;
  logic                  fifo_empty;

  // Handshake and period-boundary decode.
  // Ready depends on the current level only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  always_comb begin
    sample_ready = (level != LW'(FIFO_DEPTH));
    fifo_empty   = (level == '0);
    push         = sample_valid && sample_ready;
    boundary     = enable && (cnt == '1);
    pop          = boundary && !fifo_empty;
    fifo_level   = level;
  end

  // Period counter. It runs while enabled and is held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CODE_WIDTH'(1);
    end else begin
      cnt <= '0;
    end
  end

  // FIFO storage. There is no reset, because occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Active duty: load the FIFO head at a boundary, and otherwise hold the last code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else if (pop) begin
      duty <= mem[rd_ptr];
    end
  end

  // Saturating count of boundaries that find the FIFO empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (boundary && fifo_empty && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end

  // Registered PWM compare. The output lags the counter by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable && (cnt < duty);
    end
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// tb_audio_pwm_dac: self-checking bench for audio_pwm_dac.
// The DUT runs with a 128-clock period so that the underrun counter can
// saturate within a short run. Duty codes are scaled from a 1024-clock period
// in proportion (256 -> 32, 768 -> 96, 300 -> 37).
module tb_audio_pwm_dac;

  localparam int CW    = 7;
  localparam int DEPTH = 4;
  localparam int P     = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          pwm_out;
  logic [2:0]    fifo_level;
  logic [7:0]    underrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  audio_pwm_dac #(.CODE_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .pwm_out        (pwm_out),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: position within the period, a queue of codes, and the active duty.
  int m_phase = 0;
  int m_duty  = 0;
  int m_und   = 0;
  bit m_pwm   = 0;
  int m_q[$];
  bit m_acc, m_bnd, m_nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_duty = 0; m_und = 0; m_pwm = 0;
      m_q.delete();
    end else begin
      m_acc = sample_valid && (m_q.size() < DEPTH);
      m_bnd = enable && (m_phase == P - 1);
      m_nxt = enable && (m_phase < m_duty);
      if (m_bnd) begin
        if (m_q.size() > 0) m_duty = m_q.pop_front();
        else if (m_und < 255) m_und++;
      end
      if (m_acc) m_q.push_back(int'(sample_in));
      m_phase = enable ? (m_phase + 1) % P : 0;
      m_pwm   = m_nxt;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pwm_out", int'(pwm_out), int'(m_pwm));
      check("sample_ready", int'(sample_ready), (m_q.size() != DEPTH) ? 1 : 0);
      check("fifo_level", int'(fifo_level), m_q.size());
      check("underrun_count", int'(underrun_count), m_und);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until just after the next boundary edge (enable must be 1).
  task automatic to_boundary();
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_phase != 0 && n < 2 * P);
    if (n >= 2 * P) begin
      n_fail++;
      $display("FAIL boundary_wait: no boundary within %0d cycles", 2 * P);
    end
  endtask

  // Observe one full period that starts right after a boundary edge.
  // Sample i reflects the counter value i-1.
  task automatic measure(output int highs, output int first, output int last);
    highs = 0; first = -1; last = 0;
    for (int i = 1; i <= P; i++) begin
      tick();
      if (pwm_out) begin
        highs++;
        if (first < 0) first = i;
      end
      if (i == P) last = int'(pwm_out);
    end
  endtask

  task automatic push_one(input int code);
    sample_in    = CW'(code);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  int h, f, l, k, bad, sum;
  int codes[5] = '{11, 22, 33, 44, 55};
  bit rdy;

  initial begin
    // Reset, then release with enable high.
    #1 rst_n = 1'b0;
    #2;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ready", int'(sample_ready), 1);
    check("rst_level", int'(fifo_level), 0);
    check("rst_und", int'(underrun_count), 0);
    repeat (3) @(posedge clk);
    #1 enable = 1'b1; rst_n = 1'b1;
    repeat (P - 1) tick();
    check("und_before_first_boundary", int'(underrun_count), 0);
    tick();
    check("und_after_first_period", int'(underrun_count), 1);

    // Duty accuracy at a quarter and three quarters of the period.
    push_one(32);
    push_one(96);
    to_boundary();
    measure(h, f, l);
    check("duty_quarter_highs", h, 32);
    check("duty_quarter_start", f, 1);
    measure(h, f, l);
    check("duty_3q_highs", h, 96);
    check("duty_3q_start", f, 1);

    // Extreme codes: zero, then the maximum code.
    push_one(0);
    push_one(P - 1);
    to_boundary();
    measure(h, f, l);
    check("code0_highs", h, 0);
    check("code0_no_pulse", f, -1);
    measure(h, f, l);
    check("codemax_highs", h, P - 1);
    check("codemax_start", f, 1);
    check("codemax_last_low", l, 0);

    // Backpressure: hold valid high with distinct codes.
    k = 0;
    sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample_in = CW'(codes[k]);
      rdy = sample_ready;
      tick();
      if (rdy) k++;
    end
    check("bp_accepted", k, 4);
    check("bp_level_full", int'(fifo_level), 4);
    check("bp_ready_low", int'(sample_ready), 0);
    to_boundary();
    check("bp_level_after_pop", int'(fifo_level), 3);
    check("bp_ready_after_pop", int'(sample_ready), 1);
    tick();
    check("bp_level_refill", int'(fifo_level), 4);
    sample_valid = 1'b0;

    // Random traffic with enable toggling, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_in    = CW'($urandom_range(0, P - 1));
      tick();
    end
    sample_valid = 1'b0;
    enable       = 1'b1;

    // Drain the FIFO, then check that a single code is held while underruns accumulate.
    repeat (6) to_boundary();
    check("drained_level", int'(fifo_level), 0);
    push_one(37);
    to_boundary();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      measure(h, f, l);
      if (h != 37) bad++;
    end
    check("hold_bad_periods", bad, 0);
    check("und_saturated", int'(underrun_count), 255);

    // Asynchronous reset mid-pulse with three samples queued.
    push_one(100);
    push_one(110);
    push_one(120);
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    check("pre_reset_level", int'(fifo_level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_level", int'(fifo_level), 0);
    check("async_rst_ready", int'(sample_ready), 1);
    check("async_rst_und", int'(underrun_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sum = 0;
    repeat (3) begin
      measure(h, f, l);
      sum += h;
    end
    check("no_stale_codes", sum, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
